// File: rtl/ddr_reset_seq_pkg.sv
// Shared types and helpers for the DDR reset/calibration sequencer.
package ddr_reset_seq_pkg;

  // Per-channel sequencer states
  typedef enum logic [2:0] {
    GL_RST    = 3'd0,
    WAIT_LOCK = 3'd1,
    SW_RST    = 3'd2,
    WAIT_CAL  = 3'd3,
    READY_DLY = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } state_t;

  // Width of each channel's retry counter field
  localparam int RETRY_W = 4;

  // Timer width: one bit more than needed for the largest duration
  function automatic int timer_width(input int t0, input int t1, input int t2, input int t3);
    int m;
    m = t0;
    m = (t1 > m) ? t1 : m;
    m = (t2 > m) ? t2 : m;
    m = (t3 > m) ? t3 : m;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ddr_reset_seq_ch.sv
// One DDR channel: input synchronisers, sequencing FSM, timer and retry counter.
// Optional calibration watchdog enabled by DDR_RESET_SEQ_CAL_TIMEOUT_EN.
module ddr_reset_seq_ch
  import ddr_reset_seq_pkg::*;
#(
  parameter int GLOBAL_RESET_TIME = 8_000_000,
  parameter int SOFT_RESET_TIME   = 8_000_000,
  parameter int READY_DELAY       = 16,
  parameter int MAX_RETRIES       = 3,
  parameter int CAL_TIMEOUT       = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               local_cal_success,
  input  logic               local_cal_fail,
  input  logic               restart,
  output logic               ddr_locked,
  output logic               gl_reset_n,
  output logic               sw_reset_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int TW = timer_width(GLOBAL_RESET_TIME, SOFT_RESET_TIME, READY_DELAY, CAL_TIMEOUT);
  localparam logic [TW-1:0]      GRT_LAST = TW'(GLOBAL_RESET_TIME - 1);
  localparam logic [TW-1:0]      SRT_LAST = TW'(SOFT_RESET_TIME - 1);
  localparam logic [TW-1:0]      RDY_LAST = TW'(READY_DELAY - 1);
  localparam logic [TW-1:0]      CAL_LAST = TW'(CAL_TIMEOUT - 1);
  localparam logic [TW-1:0]      TIMER_ONE = TW'(1);
  localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRIES);
`ifdef DDR_RESET_SEQ_CAL_TIMEOUT_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  logic [1:0]         lock_sync_r, succ_sync_r, cfail_sync_r;
  logic               lock_s, succ_s, cfail_s, timeout_s, counting_s;
  state_t             state_r, state_next_s, retry_state_s;
  logic [TW-1:0]      timer_r, timer_next_s;
  logic [RETRY_W-1:0] retry_r, retry_next_s, retry_inc_s;

  // Two-flop synchronisers for the asynchronous controller status inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_r  <= 2'b00;
      succ_sync_r  <= 2'b00;
      cfail_sync_r <= 2'b00;
    end else begin
      lock_sync_r  <= {lock_sync_r[0], pll_locked};
      succ_sync_r  <= {succ_sync_r[0], local_cal_success};
      cfail_sync_r <= {cfail_sync_r[0], local_cal_fail};
    end
  end

  assign lock_s     = lock_sync_r[1];
  assign succ_s     = succ_sync_r[1];
  assign cfail_s    = cfail_sync_r[1];
  assign ddr_locked = lock_sync_r[1];
  assign retry_count = retry_r;

  // Next state, retry bookkeeping and timer; restart > lock loss > cfail > succ
  always_comb begin
    state_next_s  = state_r;
    retry_next_s  = retry_r;
    timer_next_s  = timer_r;
    timeout_s     = WDOG_EN && (state_r == WAIT_CAL) && (timer_r == CAL_LAST);
    // A failed attempt retries while budget remains, otherwise gives up
    retry_state_s = (retry_r < MAX_R) ? SW_RST : FAIL;
    retry_inc_s   = (retry_r < MAX_R) ? (retry_r + 4'd1) : retry_r;

    if (restart) begin
      state_next_s = GL_RST;
      retry_next_s = 4'd0;
    end else if (!lock_s && (state_r != GL_RST) && (state_r != WAIT_LOCK) && (state_r != FAIL)) begin
      state_next_s = GL_RST;
    end else begin
      case (state_r)
        GL_RST: begin
          if (timer_r == GRT_LAST) state_next_s = WAIT_LOCK;
          else                     state_next_s = GL_RST;
        end
        WAIT_LOCK: begin
          if (lock_s) state_next_s = SW_RST;
          else        state_next_s = WAIT_LOCK;
        end
        SW_RST: begin
          if (timer_r == SRT_LAST) state_next_s = WAIT_CAL;
          else                     state_next_s = SW_RST;
        end
        WAIT_CAL: begin
          if (cfail_s || timeout_s) begin
            state_next_s = retry_state_s;
            retry_next_s = retry_inc_s;
          end else if (succ_s) begin
            state_next_s = READY_DLY;
          end else begin
            state_next_s = WAIT_CAL;
          end
        end
        READY_DLY: begin
          if (cfail_s || !succ_s) begin
            state_next_s = retry_state_s;
            retry_next_s = retry_inc_s;
          end else if (timer_r == RDY_LAST) begin
            state_next_s = READY;
          end else begin
            state_next_s = READY_DLY;
          end
        end
        READY: begin
          if (cfail_s || !succ_s) begin
            state_next_s = retry_state_s;
            retry_next_s = retry_inc_s;
          end else begin
            state_next_s = READY;
          end
        end
        FAIL:    state_next_s = FAIL;
        default: state_next_s = GL_RST;
      endcase
    end

    // Timer restarts on every state entry and only runs in timed states
    counting_s = (state_r == GL_RST) || (state_r == SW_RST) || (state_r == READY_DLY) ||
                 (WDOG_EN && (state_r == WAIT_CAL));
    if (restart || (state_next_s != state_r)) timer_next_s = '0;
    else if (counting_s)                      timer_next_s = timer_r + TIMER_ONE;
    else                                      timer_next_s = '0;
  end

  // State, timer and retry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GL_RST;
      timer_r <= '0;
      retry_r <= 4'd0;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
      retry_r <= retry_next_s;
    end
  end

  // Output flags decoded from the next state so they switch with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gl_reset_n <= 1'b0;
      sw_reset_n <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      gl_reset_n <= (state_next_s != GL_RST);
      sw_reset_n <= (state_next_s == WAIT_CAL) || (state_next_s == READY_DLY) ||
                    (state_next_s == READY);
      ready      <= (state_next_s == READY);
      fail       <= (state_next_s == FAIL);
    end
  end

endmodule

// File: rtl/ddr_reset_seq.sv
// Multi-channel DDR reset and calibration sequencer top level.
// Define DDR_RESET_SEQ_CAL_TIMEOUT_EN to enable the per-channel calibration watchdog.
module ddr_reset_seq
  import ddr_reset_seq_pkg::*;
#(
  parameter int CHANNELS          = 2,
  parameter int GLOBAL_RESET_TIME = 8_000_000,
  parameter int SOFT_RESET_TIME   = 8_000_000,
  parameter int READY_DELAY       = 16,
  parameter int MAX_RETRIES       = 3,
  parameter int CAL_TIMEOUT       = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   pll_locked,
  input  logic [CHANNELS-1:0]   local_cal_success,
  input  logic [CHANNELS-1:0]   local_cal_fail,
  input  logic [CHANNELS-1:0]   restart,
  output logic [CHANNELS-1:0]   ddr_locked,
  output logic [CHANNELS-1:0]   gl_reset_n,
  output logic [CHANNELS-1:0]   sw_reset_n,
  output logic [CHANNELS-1:0]   ready,
  output logic [CHANNELS-1:0]   fail,
  output logic                  all_ready,
  output logic [4*CHANNELS-1:0] retry_count
);

  logic [1:0] rst_sync_r;
  logic       rst_int_n_s;

  // Reset synchroniser: asserts asynchronously, releases after two clock edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_r <= 2'b00;
    else          rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign rst_int_n_s = rst_sync_r[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ddr_reset_seq_ch #(
      .GLOBAL_RESET_TIME (GLOBAL_RESET_TIME),
      .SOFT_RESET_TIME   (SOFT_RESET_TIME),
      .READY_DELAY       (READY_DELAY),
      .MAX_RETRIES       (MAX_RETRIES),
      .CAL_TIMEOUT       (CAL_TIMEOUT)
    ) u_ch (
      .clk               (clk),
      .rst_n             (rst_int_n_s),
      .pll_locked        (pll_locked[i]),
      .local_cal_success (local_cal_success[i]),
      .local_cal_fail    (local_cal_fail[i]),
      .restart           (restart[i]),
      .ddr_locked        (ddr_locked[i]),
      .gl_reset_n        (gl_reset_n[i]),
      .sw_reset_n        (sw_reset_n[i]),
      .ready             (ready[i]),
      .fail              (fail[i]),
      .retry_count       (retry_count[RETRY_W*i +: RETRY_W])
    );
  end

  // Combined ready flag, registered so it trails the channel flags by one cycle
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) all_ready <= 1'b0;
    else              all_ready <= &ready;
  end

endmodule

// File: tb/tb_ddr_reset_seq.sv
// Self-checking bench for ddr_reset_seq: expected latencies are queued when
// stimulus is applied and compared when the DUT reaches the awaited level.
module tb_ddr_reset_seq;

  localparam int CH   = 2;
  localparam int GRT  = 8;
  localparam int SRT  = 4;
  localparam int RDY  = 3;
  localparam int MAXR = 2;
  localparam int CTO  = 20;

  localparam int SEL_GL  = 0;
  localparam int SEL_SW  = 1;
  localparam int SEL_RDY = 2;
  localparam int SEL_FL  = 3;
  localparam int SEL_ALL = 4;

  logic            clk;
  logic            reset_n;
  logic [CH-1:0]   pll_locked, local_cal_success, local_cal_fail, restart;
  logic [CH-1:0]   ddr_locked, gl_reset_n, sw_reset_n, ready, fail;
  logic            all_ready;
  logic [4*CH-1:0] retry_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  ddr_reset_seq #(
    .CHANNELS(CH), .GLOBAL_RESET_TIME(GRT), .SOFT_RESET_TIME(SRT),
    .READY_DELAY(RDY), .MAX_RETRIES(MAXR), .CAL_TIMEOUT(CTO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .local_cal_success(local_cal_success), .local_cal_fail(local_cal_fail),
    .restart(restart), .ddr_locked(ddr_locked), .gl_reset_n(gl_reset_n),
    .sw_reset_n(sw_reset_n), .ready(ready), .fail(fail),
    .all_ready(all_ready), .retry_count(retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int obs);
    int e;
    e = -999;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_val(tag, obs, e);
  endtask

  function automatic logic sig(input int sel, input int ch);
    case (sel)
      SEL_GL:  return gl_reset_n[ch];
      SEL_SW:  return sw_reset_n[ch];
      SEL_RDY: return ready[ch];
      SEL_FL:  return fail[ch];
      SEL_ALL: return all_ready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int retry_of(input int ch);
    return int'(retry_count[4*ch +: 4]);
  endfunction

  // Count falling edges until the selected output reaches val; -1 on budget expiry
  task automatic wait_for(input int sel, input int ch, input logic val, input int budget, output int n);
    n = 0;
    while (sig(sel, ch) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel, ch) !== val) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not complete, got stuck, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    pll_locked = 2'b11;
    local_cal_success = 2'b00;
    local_cal_fail = 2'b00;
    restart = 2'b00;
    repeat (4) @(negedge clk);

    // Reset state
    check_val("rst_gl", int'(gl_reset_n), 0);
    check_val("rst_sw", int'(sw_reset_n), 0);
    check_val("rst_ready", int'(ready), 0);
    check_val("rst_fail", int'(fail), 0);
    check_val("rst_all_ready", int'(all_ready), 0);
    check_val("rst_retry", int'(retry_count), 0);
    check_val("rst_locked", int'(ddr_locked), 0);

    // Nominal bring-up (2 extra cycles from the reset synchroniser)
    reset_n = 1'b1;
    exp_q.push_back(GRT + 2);
    wait_for(SEL_GL, 0, 1'b1, 100, n); sb_check("nom_gl_low", n);
    check_val("nom_gl_ch1", int'(gl_reset_n[1]), 1);
    check_val("nom_locked", int'(ddr_locked), 3);
    exp_q.push_back(SRT + 1);
    wait_for(SEL_SW, 0, 1'b1, 100, n); sb_check("nom_sw_rise", n);
    check_val("nom_sw_ch1", int'(sw_reset_n[1]), 1);
    repeat (5) @(negedge clk);
    local_cal_success[0] = 1'b1;
    exp_q.push_back(RDY + 3);
    wait_for(SEL_RDY, 0, 1'b1, 50, n); sb_check("nom_ready0", n);
    check_val("nom_all_ready_early", int'(all_ready), 0);
    local_cal_success[1] = 1'b1;
    exp_q.push_back(RDY + 3);
    wait_for(SEL_RDY, 1, 1'b1, 50, n); sb_check("nom_ready1", n);
    exp_q.push_back(1);
    wait_for(SEL_ALL, 0, 1'b1, 10, n); sb_check("nom_all_ready_lag", n);
    check_val("nom_retry", int'(retry_count), 0);

    // Retry exhaustion on channel 0
    local_cal_success[0] = 1'b0;
    restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    check_val("rx_restart_ready", int'(ready[0]), 0);
    for (int a = 0; a <= MAXR; a++) begin
      exp_q.push_back((a == 0) ? (GRT + SRT + 1) : 0);
      wait_for(SEL_SW, 0, 1'b1, 100, n); sb_check("rx_reach_wait_cal", n);
      local_cal_fail[0] = 1'b1;
      exp_q.push_back(3);
      if (a < MAXR) begin
        wait_for(SEL_SW, 0, 1'b0, 20, n); sb_check("rx_sw_fall", n);
        local_cal_fail[0] = 1'b0;
        exp_q.push_back(SRT);
        wait_for(SEL_SW, 0, 1'b1, 20, n); sb_check("rx_sw_pulse", n);
        check_val("rx_retry_count", retry_of(0), a + 1);
      end else begin
        wait_for(SEL_FL, 0, 1'b1, 20, n); sb_check("rx_fail_rise", n);
        local_cal_fail[0] = 1'b0;
      end
    end
    check_val("rx_ready0", int'(ready[0]), 0);
    check_val("rx_sw0", int'(sw_reset_n[0]), 0);
    check_val("rx_retry_sat", retry_of(0), MAXR);
    check_val("rx_ch1_ready", int'(ready[1]), 1);
    check_val("rx_ch1_retry", retry_of(1), 0);
    check_val("rx_all_ready", int'(all_ready), 0);
    repeat (10) @(negedge clk);
    check_val("rx_fail_sticky", int'(fail[0]), 1);

    // Restart from FAIL
    restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    check_val("rs_fail_clr", int'(fail[0]), 0);
    check_val("rs_gl_low", int'(gl_reset_n[0]), 0);
    check_val("rs_retry_clr", retry_of(0), 0);
    exp_q.push_back(GRT);
    wait_for(SEL_GL, 0, 1'b1, 50, n); sb_check("rs_gl_width", n);
    exp_q.push_back(SRT + 1);
    wait_for(SEL_SW, 0, 1'b1, 50, n); sb_check("rs_sw_rise", n);
    local_cal_success[0] = 1'b1;
    exp_q.push_back(RDY + 3);
    wait_for(SEL_RDY, 0, 1'b1, 50, n); sb_check("rs_ready0", n);

    // Success drop in READY on channel 1 takes the retry path
    local_cal_success[1] = 1'b0;
    exp_q.push_back(3);
    wait_for(SEL_RDY, 1, 1'b0, 20, n); sb_check("sd_ready_fall", n);
    check_val("sd_retry", retry_of(1), 1);
    exp_q.push_back(SRT);
    wait_for(SEL_SW, 1, 1'b1, 20, n); sb_check("sd_sw_pulse", n);

    // Simultaneous success and fail counts as a fail
    local_cal_success[1] = 1'b1;
    local_cal_fail[1] = 1'b1;
    exp_q.push_back(3);
    wait_for(SEL_SW, 1, 1'b0, 20, n); sb_check("sf_sw_fall", n);
    local_cal_success[1] = 1'b0;
    local_cal_fail[1] = 1'b0;
    check_val("sf_retry", retry_of(1), 2);
    check_val("sf_no_ready", int'(ready[1]), 0);
    exp_q.push_back(SRT);
    wait_for(SEL_SW, 1, 1'b1, 20, n); sb_check("sf_sw_pulse", n);
    check_val("sf_no_ready_after", int'(ready[1]), 0);
    local_cal_success[1] = 1'b1;
    exp_q.push_back(RDY + 3);
    wait_for(SEL_RDY, 1, 1'b1, 50, n); sb_check("sf_ready1", n);
    exp_q.push_back(1);
    wait_for(SEL_ALL, 0, 1'b1, 10, n); sb_check("sf_all_ready", n);

    // Lock loss on channel 1 in READY
    pll_locked[1] = 1'b0;
    exp_q.push_back(3);
    wait_for(SEL_RDY, 1, 1'b0, 20, n); sb_check("ll_ready_fall", n);
    check_val("ll_gl_low", int'(gl_reset_n[1]), 0);
    check_val("ll_ddr_locked", int'(ddr_locked[1]), 0);
    pll_locked[1] = 1'b1;
    exp_q.push_back(GRT);
    wait_for(SEL_GL, 1, 1'b1, 50, n); sb_check("ll_gl_width", n);
    exp_q.push_back(SRT + 1);
    wait_for(SEL_SW, 1, 1'b1, 50, n); sb_check("ll_sw_rise", n);
    exp_q.push_back(RDY + 1);
    wait_for(SEL_RDY, 1, 1'b1, 50, n); sb_check("ll_ready_again", n);
    check_val("ll_retry_kept", retry_of(1), 2);

    // Calibration watchdog on channel 0
    local_cal_success[0] = 1'b0;
    restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    exp_q.push_back(GRT + SRT + 1);
    wait_for(SEL_SW, 0, 1'b1, 100, n); sb_check("wd_reach_wait_cal", n);
`ifdef DDR_RESET_SEQ_CAL_TIMEOUT_EN
    exp_q.push_back(CTO);
    wait_for(SEL_SW, 0, 1'b0, 3 * CTO, n); sb_check("wd_timeout", n);
    check_val("wd_retry", retry_of(0), 1);
`else
    exp_q.push_back(-1);
    wait_for(SEL_SW, 0, 1'b0, 3 * CTO, n); sb_check("wd_absent", n);
    check_val("wd_retry", retry_of(0), 0);
    check_val("wd_still_wait_cal", int'(sw_reset_n[0]), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
